// File: rtl/pu_or1k_pfpu32_seq.sv
// pu_or1k_pfpu32_seq: single-issue sequencer for the pfpu32 FPU.
// Accepts one FP op, pulses a one-hot unit start, drives the shared
// advance/flush strobes, counts the unit latency and holds the result
// handshake until the CPU takes it.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush_i / flush_o   flush request in, flush strobe to units (comb)
//   op_valid_i          request, op_code_i selects the operation
//   op_ready_o          request can be accepted (IDLE, no flush/rst)
//   start_o, sub_o      one-hot unit start, subtract select
//   adv_o               advance strobe to unit pipelines
//   busy_o              operation in flight
//   result_valid_o      result available, with result_unit_o and
//                       result_illegal_o; result_taken_i consumes it
//
// Optional feature: define OR1K_PFPU32_DIV_EN to sequence op 011 (div);
// otherwise it is rejected as illegal and start_o[2] is tied to 0.
module pu_or1k_pfpu32_seq #(
    parameter int LAT_ADDSUB = 3,
    parameter int LAT_MUL    = 3,
    parameter int LAT_DIV    = 12,
    parameter int LAT_CNV    = 2,
    parameter int LAT_CMP    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush_i,
    input  logic       op_valid_i,
    input  logic [2:0] op_code_i,
    output logic       op_ready_o,
    output logic [5:0] start_o,
    output logic       sub_o,
    output logic       adv_o,
    output logic       flush_o,
    output logic       busy_o,
    output logic       result_valid_o,
    output logic [5:0] result_unit_o,
    output logic       result_illegal_o,
    input  logic       result_taken_i
);

    if (LAT_ADDSUB < 1 || LAT_ADDSUB > 15) begin : g_bad_addsub
        $error("LAT_ADDSUB out of range 1-15");
    end
    if (LAT_MUL < 1 || LAT_MUL > 15) begin : g_bad_mul
        $error("LAT_MUL out of range 1-15");
    end
    if (LAT_DIV < 1 || LAT_DIV > 15) begin : g_bad_div
        $error("LAT_DIV out of range 1-15");
    end
    if (LAT_CNV < 1 || LAT_CNV > 15) begin : g_bad_cnv
        $error("LAT_CNV out of range 1-15");
    end
    if (LAT_CMP < 1 || LAT_CMP > 15) begin : g_bad_cmp
        $error("LAT_CMP out of range 1-15");
    end

    localparam logic [5:0] U_ADDSUB = 6'b000001;
    localparam logic [5:0] U_MUL    = 6'b000010;
    localparam logic [5:0] U_I2F    = 6'b001000;
    localparam logic [5:0] U_F2I    = 6'b010000;
    localparam logic [5:0] U_CMP    = 6'b100000;

`ifdef OR1K_PFPU32_DIV_EN
    localparam logic [5:0] U_DIV      = 6'b000100;
    localparam logic [5:0] START_MASK = 6'b111111;
`else
    localparam logic [5:0] START_MASK = 6'b111011;
`endif

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t     state;
    logic [3:0] cnt;
    logic [5:0] unit_q;
    logic [5:0] start_q;

    logic       accept;
    logic       dec_legal;
    logic [5:0] dec_unit;
    logic [3:0] dec_cnt;

    assign op_ready_o = (state == IDLE) & ~flush_i & ~rst;
    assign accept     = op_valid_i & op_ready_o;
    assign flush_o    = flush_i;
    assign start_o    = start_q & START_MASK;

    // Counter preload is L-1 so that RUN lasts exactly L cycles.
    always_comb begin
        dec_legal = 1'b0;
        dec_unit  = 6'b0;
        dec_cnt   = 4'd0;
        case (op_code_i)
            3'b000, 3'b001: begin
                dec_legal = 1'b1;
                dec_unit  = U_ADDSUB;
                dec_cnt   = 4'(LAT_ADDSUB - 1);
            end
            3'b010: begin
                dec_legal = 1'b1;
                dec_unit  = U_MUL;
                dec_cnt   = 4'(LAT_MUL - 1);
            end
`ifdef OR1K_PFPU32_DIV_EN
            3'b011: begin
                dec_legal = 1'b1;
                dec_unit  = U_DIV;
                dec_cnt   = 4'(LAT_DIV - 1);
            end
`endif
            3'b100: begin
                dec_legal = 1'b1;
                dec_unit  = U_I2F;
                dec_cnt   = 4'(LAT_CNV - 1);
            end
            3'b101: begin
                dec_legal = 1'b1;
                dec_unit  = U_F2I;
                dec_cnt   = 4'(LAT_CNV - 1);
            end
            3'b110: begin
                dec_legal = 1'b1;
                dec_unit  = U_CMP;
                dec_cnt   = 4'(LAT_CMP - 1);
            end
            default: begin
                dec_legal = 1'b0;
                dec_unit  = 6'b0;
                dec_cnt   = 4'd0;
            end
        endcase
    end

    // Flush shares the reset path: it beats accept and result_taken_i.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            state            <= IDLE;
            cnt              <= 4'd0;
            unit_q           <= 6'b0;
            start_q          <= 6'b0;
            sub_o            <= 1'b0;
            adv_o            <= 1'b0;
            busy_o           <= 1'b0;
            result_valid_o   <= 1'b0;
            result_unit_o    <= 6'b0;
            result_illegal_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        busy_o <= 1'b1;
                        if (dec_legal) begin
                            state   <= RUN;
                            cnt     <= dec_cnt;
                            unit_q  <= dec_unit;
                            start_q <= dec_unit;
                            sub_o   <= (op_code_i == 3'b001);
                            adv_o   <= 1'b1;
                        end else begin
                            state            <= DONE;
                            result_valid_o   <= 1'b1;
                            result_unit_o    <= 6'b0;
                            result_illegal_o <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    start_q <= 6'b0;
                    sub_o   <= 1'b0;
                    if (cnt == 4'd0) begin
                        state          <= DONE;
                        adv_o          <= 1'b0;
                        result_valid_o <= 1'b1;
                        result_unit_o  <= unit_q;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (result_taken_i) begin
                        state            <= IDLE;
                        busy_o           <= 1'b0;
                        unit_q           <= 6'b0;
                        result_valid_o   <= 1'b0;
                        result_unit_o    <= 6'b0;
                        result_illegal_o <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pu_or1k_pfpu32_seq.sv
// Testbench for pu_or1k_pfpu32_seq: directed requests with a scoreboard
// of expected results checked by an independent monitor.
module tb_pu_or1k_pfpu32_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush_i;
    logic       op_valid_i;
    logic [2:0] op_code_i;
    logic       op_ready_o;
    logic [5:0] start_o;
    logic       sub_o;
    logic       adv_o;
    logic       flush_o;
    logic       busy_o;
    logic       result_valid_o;
    logic [5:0] result_unit_o;
    logic       result_illegal_o;
    logic       result_taken_i;

    pu_or1k_pfpu32_seq dut (
        .clk              (clk),
        .rst              (rst),
        .flush_i          (flush_i),
        .op_valid_i       (op_valid_i),
        .op_code_i        (op_code_i),
        .op_ready_o       (op_ready_o),
        .start_o          (start_o),
        .sub_o            (sub_o),
        .adv_o            (adv_o),
        .flush_o          (flush_o),
        .busy_o           (busy_o),
        .result_valid_o   (result_valid_o),
        .result_unit_o    (result_unit_o),
        .result_illegal_o (result_illegal_o),
        .result_taken_i   (result_taken_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] unit;
        logic       illegal;
        int         due;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: each rising result_valid_o must match the oldest expectation.
    always @(negedge clk) begin
        if (result_valid_o === 1'b1 && prev_valid !== 1'b1) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: got valid=1 want no result");
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("res_unit", 32'(result_unit_o), 32'(e.unit));
                chk("res_illegal", 32'(result_illegal_o), 32'(e.illegal));
                chk("res_cycle", 32'(cyc), 32'(e.due));
            end
        end
        prev_valid <= result_valid_o;
    end

    // Issue one op; lat is the RUN length (0 for illegal ops), dly the
    // number of valid cycles before result_taken_i (0: held high all along).
    task automatic issue(input logic [2:0] op, input logic [5:0] ust,
                         input logic sb, input int lat, input logic ill,
                         input int dly);
        int acc;
        exp_t e;
        @(negedge clk);
        op_valid_i     = 1'b1;
        op_code_i      = op;
        result_taken_i = (dly == 0);
        chk("op_ready_idle", 32'(op_ready_o), 32'd1);
        @(posedge clk);
        #1;
        acc = cyc;
        op_valid_i = 1'b0;
        e.unit    = ill ? 6'b0 : ust;
        e.illegal = ill;
        e.due     = ill ? acc : acc + lat;
        q.push_back(e);
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            chk("run_start", 32'(start_o), 32'((i == 1) ? ust : 6'b0));
            chk("run_sub", 32'(sub_o), 32'((i == 1) ? sb : 1'b0));
            chk("run_adv", 32'(adv_o), 32'd1);
            chk("run_busy", 32'(busy_o), 32'd1);
        end
        @(negedge clk);
        chk("done_start", 32'(start_o), 32'd0);
        chk("done_adv", 32'(adv_o), 32'd0);
        chk("done_ready", 32'(op_ready_o), 32'd0);
        for (int k = 0; k < dly; k++) begin
            chk("hold_valid", 32'(result_valid_o), 32'd1);
            chk("hold_adv", 32'(adv_o), 32'd0);
            @(negedge clk);
        end
        chk("take_valid", 32'(result_valid_o), 32'd1);
        result_taken_i = 1'b1;
        @(negedge clk);
        result_taken_i = 1'b0;
        chk("post_valid", 32'(result_valid_o), 32'd0);
        chk("post_ready", 32'(op_ready_o), 32'd1);
        chk("post_busy", 32'(busy_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        flush_i        = 1'b0;
        op_valid_i     = 1'b0;
        op_code_i      = 3'b000;
        result_taken_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(op_ready_o), 32'd0);
        chk("rst_start", 32'(start_o), 32'd0);
        chk("rst_adv", 32'(adv_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_valid", 32'(result_valid_o), 32'd0);
        chk("rst_unit", 32'(result_unit_o), 32'd0);
        chk("rst_illegal", 32'(result_illegal_o), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_off_ready", 32'(op_ready_o), 32'd1);

        issue(3'b101, 6'b010000, 1'b0, 2, 1'b0, 0);  // f2i
        issue(3'b001, 6'b000001, 1'b1, 3, 1'b0, 5);  // sub
        issue(3'b000, 6'b000001, 1'b0, 3, 1'b0, 1);  // add
        issue(3'b010, 6'b000010, 1'b0, 3, 1'b0, 0);  // mul
        issue(3'b100, 6'b001000, 1'b0, 2, 1'b0, 2);  // i2f
        issue(3'b110, 6'b100000, 1'b0, 1, 1'b0, 0);  // cmp
`ifdef OR1K_PFPU32_DIV_EN
        issue(3'b011, 6'b000100, 1'b0, 12, 1'b0, 0); // div
`else
        issue(3'b011, 6'b000000, 1'b0, 0, 1'b1, 0);  // div rejected
`endif
        issue(3'b111, 6'b000000, 1'b0, 0, 1'b1, 1);  // reserved

        // mul accepted, flush in cycle 2
        @(negedge clk);
        op_valid_i = 1'b1;
        op_code_i  = 3'b010;
        @(posedge clk);
        #1;
        op_valid_i = 1'b0;
        @(negedge clk);
        chk("fl_c1_start", 32'(start_o), 32'b000010);
        @(negedge clk);
        flush_i = 1'b1;
        #1;
        chk("fl_flush_o", 32'(flush_o), 32'd1);
        chk("fl_ready", 32'(op_ready_o), 32'd0);
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        chk("fl_busy", 32'(busy_o), 32'd0);
        chk("fl_adv", 32'(adv_o), 32'd0);
        chk("fl_ready_after", 32'(op_ready_o), 32'd1);
        chk("fl_flush_low", 32'(flush_o), 32'd0);

        // request together with flush is not taken
        @(negedge clk);
        op_valid_i = 1'b1;
        op_code_i  = 3'b110;
        flush_i    = 1'b1;
        #1;
        chk("flv_ready", 32'(op_ready_o), 32'd0);
        @(negedge clk);
        op_valid_i = 1'b0;
        flush_i    = 1'b0;
        chk("flv_busy", 32'(busy_o), 32'd0);
        chk("flv_start", 32'(start_o), 32'd0);
        repeat (4) @(negedge clk);

        // rst pulsed while a cmp result waits in DONE
        op_valid_i = 1'b1;
        op_code_i  = 3'b110;
        begin
            exp_t e;
            @(posedge clk);
            #1;
            op_valid_i = 1'b0;
            e.unit    = 6'b100000;
            e.illegal = 1'b0;
            e.due     = cyc + 1;
            q.push_back(e);
        end
        repeat (2) @(negedge clk);
        chk("rd_valid", 32'(result_valid_o), 32'd1);
        rst = 1'b1;
        #1;
        chk("rd_ready_rst", 32'(op_ready_o), 32'd0);
        @(negedge clk);
        chk("rd_valid_clr", 32'(result_valid_o), 32'd0);
        chk("rd_unit_clr", 32'(result_unit_o), 32'd0);
        chk("rd_busy_clr", 32'(busy_o), 32'd0);
        chk("rd_adv_clr", 32'(adv_o), 32'd0);
        rst = 1'b0;
        #1;
        chk("rd_ready", 32'(op_ready_o), 32'd1);

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
